// File: rtl/ps2_message_buffer.sv
// ps2_message_buffer: PS/2 set-2 key capture into a fixed message buffer with echo and send handshake.
// Revision: 1.0
`default_nettype none

module ps2_message_buffer #(
  parameter int DEPTH  = 16,
  parameter int CHAR_W = 8,
  parameter int WRAP   = 0
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           key_valid,
  input  logic [7:0]                     key_code,
  input  logic                           send_req,
  input  logic                           tx_ready,
  output logic                           tx_valid,
  output logic [DEPTH*CHAR_W-1:0]        message,
  output logic [$clog2(DEPTH+1)-1:0]     char_count,
  output logic                           char_valid,
  output logic [7:0]                     char_out,
  output logic                           full,
  output logic                           overflow
);

  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  typedef enum logic [1:0] {S_EDIT = 2'd0, S_HOLD = 2'd1, S_CLEAR = 2'd2} state_t;

  state_t             r_state;
  logic [CHAR_W-1:0]  r_slot [DEPTH];
  logic [CW-1:0]      r_count;
  logic               r_brk;
  logic               r_tx_valid;
  logic               r_char_valid;
  logic [7:0]         r_char_out;
  logic               r_overflow;

  logic [7:0]         w_ascii;
  logic               w_print;
  logic               w_del;
  logic               w_enter;
  logic               w_key;
  logic               w_full;
  logic [CW-1:0]      w_cnt_after;
  logic               w_go;

  always_comb begin
    w_ascii = 8'h00;
    w_print = 1'b1;
    w_del   = 1'b0;
    w_enter = 1'b0;
    case (key_code)
      8'h1C: w_ascii = "a";  8'h32: w_ascii = "b";  8'h21: w_ascii = "c";
      8'h23: w_ascii = "d";  8'h24: w_ascii = "e";  8'h2B: w_ascii = "f";
      8'h34: w_ascii = "g";  8'h33: w_ascii = "h";  8'h43: w_ascii = "i";
      8'h3B: w_ascii = "j";  8'h42: w_ascii = "k";  8'h4B: w_ascii = "l";
      8'h3A: w_ascii = "m";  8'h31: w_ascii = "n";  8'h44: w_ascii = "o";
      8'h4D: w_ascii = "p";  8'h15: w_ascii = "q";  8'h2D: w_ascii = "r";
      8'h1B: w_ascii = "s";  8'h2C: w_ascii = "t";  8'h3C: w_ascii = "u";
      8'h2A: w_ascii = "v";  8'h1D: w_ascii = "w";  8'h22: w_ascii = "x";
      8'h35: w_ascii = "y";  8'h1A: w_ascii = "z";  8'h29: w_ascii = 8'h20;
      8'h66: begin w_print = 1'b0; w_del   = 1'b1; end
      8'h5A: begin w_print = 1'b0; w_enter = 1'b1; end
      default: w_print = 1'b0;
    endcase
  end

  // A code that follows a break prefix (0xF0) is a key release and is dropped.
  assign w_key  = key_valid && !r_brk && (key_code != 8'hF0);
  assign w_full = (r_count == C_DEPTH);

  // Count after the key is applied, so a simultaneous send sees the updated buffer.
  always_comb begin
    w_cnt_after = r_count;
    if (w_key && w_print) begin
      if (!w_full)       w_cnt_after = r_count + C_ONE;
      else if (WRAP != 0) w_cnt_after = C_ONE;
    end else if (w_key && w_del && (r_count != '0)) begin
      w_cnt_after = r_count - C_ONE;
    end
    w_go = (send_req || (w_key && w_enter)) && (w_cnt_after != '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_EDIT;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_count      <= '0;
      r_brk        <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_char_valid <= 1'b0;
      r_char_out   <= 8'h00;
      r_overflow   <= 1'b0;
    end else begin
      r_char_valid <= 1'b0;
      if (key_valid) r_brk <= (key_code == 8'hF0) && !r_brk;
      case (r_state)
        S_EDIT: begin
          if (w_key && w_print) begin
            if (!w_full) begin
              for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == r_count) r_slot[i] <= CHAR_W'(w_ascii);
              r_count      <= r_count + C_ONE;
              r_char_valid <= 1'b1;
              r_char_out   <= w_ascii;
            end else if (WRAP != 0) begin
              for (int i = 0; i < DEPTH; i++)
                r_slot[i] <= (i == 0) ? CHAR_W'(w_ascii) : '0;
              r_count      <= C_ONE;
              r_char_valid <= 1'b1;
              r_char_out   <= w_ascii;
            end else begin
              r_overflow <= 1'b1;
            end
          end else if (w_key && w_del && (r_count != '0)) begin
            for (int i = 0; i < DEPTH; i++)
              if (CW'(i) == (r_count - C_ONE)) r_slot[i] <= '0;
            r_count      <= r_count - C_ONE;
            r_char_valid <= 1'b1;
            r_char_out   <= 8'h7F;
          end
          if (w_go) begin
            r_state    <= S_HOLD;
            r_tx_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (key_valid || send_req) r_overflow <= 1'b1;
          if (tx_ready) begin
            r_state    <= S_CLEAR;
            r_tx_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
            r_count    <= '0;
          end
        end
        default: begin
          if (key_valid || send_req) r_overflow <= 1'b1;
          r_state <= S_EDIT;
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign message[(DEPTH-g)*CHAR_W-1 -: CHAR_W] = r_slot[g];
  end

  assign tx_valid   = r_tx_valid;
  assign char_count = r_count;
  assign char_valid = r_char_valid;
  assign char_out   = r_char_out;
  assign full       = w_full;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_message_buffer.sv
// tb_ps2_message_buffer: scoreboard bench for the PS/2 message buffer (DEPTH 16, plus DEPTH 4 with both full policies).
// Revision: 1.0
`default_nettype none

module tb_ps2_message_buffer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         key_valid;
  logic [7:0]   key_code;
  logic         send_req;
  logic         tx_ready;

  logic         tx_valid, char_valid, full, overflow;
  logic [127:0] message;
  logic [4:0]   char_count;
  logic [7:0]   char_out;

  logic         tv_a, cv_a, full_a, ovf_a, tv_b, cv_b, full_b, ovf_b;
  logic [31:0]  msg_a, msg_b;
  logic [2:0]   cnt_a, cnt_b;
  logic [7:0]   co_a, co_b;

  int checks = 0;
  int fails  = 0;
  int n_cv_a = 0;
  int n_cv_b = 0;

  typedef struct { int cnt; logic [15:0] top; } tx_t;
  logic [7:0] exp_echo[$];
  tx_t        exp_tx[$];

  always #5 clk = ~clk;

  ps2_message_buffer #(.DEPTH(16), .CHAR_W(8), .WRAP(0)) dut (
    .clock(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
    .send_req(send_req), .tx_ready(tx_ready), .tx_valid(tx_valid), .message(message),
    .char_count(char_count), .char_valid(char_valid), .char_out(char_out),
    .full(full), .overflow(overflow));

  ps2_message_buffer #(.DEPTH(4), .CHAR_W(8), .WRAP(0)) dut_a (
    .clock(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
    .send_req(send_req), .tx_ready(tx_ready), .tx_valid(tv_a), .message(msg_a),
    .char_count(cnt_a), .char_valid(cv_a), .char_out(co_a),
    .full(full_a), .overflow(ovf_a));

  ps2_message_buffer #(.DEPTH(4), .CHAR_W(8), .WRAP(1)) dut_b (
    .clock(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
    .send_req(send_req), .tx_ready(tx_ready), .tx_valid(tv_b), .message(msg_b),
    .char_count(cnt_b), .char_valid(cv_b), .char_out(co_b),
    .full(full_b), .overflow(ovf_b));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every echo and every accepted message against the queues.
  always @(negedge clk) begin
    if (cv_a) n_cv_a++;
    if (cv_b) n_cv_b++;
    if (char_valid) begin
      if (exp_echo.size() == 0) chk("echo_unexpected", {120'd0, char_out}, 128'hDEAD);
      else chk("echo", {120'd0, char_out}, {120'd0, exp_echo.pop_front()});
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", {123'd0, char_count}, 128'hDEAD);
      else begin
        tx_t e;
        e = exp_tx.pop_front();
        chk("tx_count", {123'd0, char_count}, 128'(e.cnt));
        chk("tx_msg", {112'd0, message[127:112]}, {112'd0, e.top});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic push_tx(input int cnt, input logic [15:0] top);
    tx_t e;
    e.cnt = cnt;
    e.top = top;
    exp_tx.push_back(e);
  endtask

  task automatic do_send(input int hold);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    repeat (hold) tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tv;
    int base_a, base_b;
    resetn = 1'b0; key_valid = 1'b0; key_code = 8'h00; send_req = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_tx_valid", {127'd0, tx_valid}, 128'd0);
    chk("rst_char_out", {120'd0, char_out}, 128'd0);
    resetn = 1'b1;
    tick();
    chk("rst_count", {123'd0, char_count}, 128'd0);
    chk("rst_message", message, 128'd0);
    chk("rst_full_ovf", {126'd0, full, overflow}, 128'd0);

    // 'h','e' then send with tx_ready low for three cycles
    exp_echo.push_back("h"); press(8'h33);
    exp_echo.push_back("e"); press(8'h24);
    chk("he_count", {123'd0, char_count}, 128'd2);
    push_tx(2, 16'h6865);
    send_req = 1'b1; tick(); send_req = 1'b0;
    n_tv = 0;
    for (int i = 0; i < 4; i++) begin
      tx_ready = (i == 3);
      if (tx_valid) n_tv++;
      if (i < 3) chk("hold_frozen", {123'd0, char_count}, 128'd2);
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_valid_cycles", 128'(n_tv), 128'd4);
    chk("clear_tx_valid", {127'd0, tx_valid}, 128'd0);
    chk("clear_count", {123'd0, char_count}, 128'd0);
    tick();

    // break prefix suppresses the release code
    exp_echo.push_back("a"); press(8'h1C);
    press(8'hF0); press(8'h1C);
    chk("brk_count", {123'd0, char_count}, 128'd1);
    chk("brk_msg", {112'd0, message[127:112]}, 128'h6100);
    push_tx(1, 16'h6100);
    do_send(1);

    // DEL sequence
    exp_echo.push_back("a"); press(8'h1C);
    exp_echo.push_back("b"); press(8'h32);
    chk("del_count2", {123'd0, char_count}, 128'd2);
    exp_echo.push_back(8'h7F); press(8'h66);
    chk("del_count1", {123'd0, char_count}, 128'd1);
    exp_echo.push_back(8'h7F); press(8'h66);
    chk("del_count0", {123'd0, char_count}, 128'd0);
    press(8'h66);
    chk("del_empty_count", {123'd0, char_count}, 128'd0);
    chk("del_message", message, 128'd0);

    // five 'a' into DEPTH=4 instances (drop vs wrap)
    base_a = n_cv_a; base_b = n_cv_b;
    for (int i = 0; i < 5; i++) begin
      exp_echo.push_back("a");
      press(8'h1C);
    end
    tick();
    chk("d4w0_count", {125'd0, cnt_a}, 128'd4);
    chk("d4w0_full_ovf", {126'd0, full_a, ovf_a}, 128'd3);
    chk("d4w0_echoes", 128'(n_cv_a - base_a), 128'd4);
    chk("d4w1_count", {125'd0, cnt_b}, 128'd1);
    chk("d4w1_echoes", 128'(n_cv_b - base_b), 128'd5);
    chk("d16_count5", {123'd0, char_count}, 128'd5);
    push_tx(5, 16'h6161);
    do_send(0);

    // keys during HOLD are discarded and flag overflow
    exp_echo.push_back("a"); press(8'h1C);
    send_req = 1'b1; tick(); send_req = 1'b0;
    press(8'h32);
    chk("hold_ovf", {127'd0, overflow}, 128'd1);
    chk("hold_tx_valid", {127'd0, tx_valid}, 128'd1);
    chk("hold_count", {123'd0, char_count}, 128'd1);
    push_tx(1, 16'h6100);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0; tick();
    chk("ovf_sticky", {127'd0, overflow}, 128'd1);

    // requests with an empty buffer are ignored; ENTER sends
    press(8'h5A);
    chk("enter_empty", {127'd0, tx_valid}, 128'd0);
    send_req = 1'b1; tick(); send_req = 1'b0;
    chk("send_empty", {127'd0, tx_valid}, 128'd0);
    exp_echo.push_back("a"); press(8'h1C);
    press(8'h5A);
    chk("enter_tx_valid", {127'd0, tx_valid}, 128'd1);
    push_tx(1, 16'h6100);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0; tick();

    // key and send in the same cycle: key applied first
    key_valid = 1'b1; key_code = 8'h32; send_req = 1'b1;
    tick();
    key_valid = 1'b0; send_req = 1'b0;
    exp_echo.push_back("b");
    chk("same_tx_valid", {127'd0, tx_valid}, 128'd1);
    chk("same_count", {123'd0, char_count}, 128'd1);
    push_tx(1, 16'h6200);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0; tick();

    // reset mid-HOLD aborts without a handshake
    exp_echo.push_back("e"); press(8'h24);
    send_req = 1'b1; tick(); send_req = 1'b0;
    chk("abort_pre", {127'd0, tx_valid}, 128'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_tx_valid", {127'd0, tx_valid}, 128'd0);
    chk("abort_count", {123'd0, char_count}, 128'd0);
    chk("abort_ovf", {127'd0, overflow}, 128'd0);
    tick(); tick();
    resetn = 1'b1;
    exp_echo.push_back("h"); press(8'h33);
    chk("post_rst_count", {123'd0, char_count}, 128'd1);
    push_tx(1, 16'h6800);
    do_send(0);

    tick();
    chk("echo_queue_empty", 128'(exp_echo.size()), 128'd0);
    chk("tx_queue_empty", 128'(exp_tx.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
